// File: rtl/grf_wb_queue.sv
// In-order writeback queue in front of the GRF write port. Requests are buffered
// in a small FIFO, committed one per granted cycle, and exposed for forwarding.
module grf_wb_queue #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 32,
  parameter  int AW    = 5,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_pc,
  input  logic          drain_en,
  output logic          WE,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] WD,
  output logic [DW-1:0] PC,
  input  logic [AW-1:0] q_addr_a,
  input  logic [AW-1:0] q_addr_b,
  output logic          hit_a,
  output logic          hit_b,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DW-1:0]    r_pc   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_idx [DEPTH];

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  // Writes to $0 finish the handshake but never occupy an entry.
  assign w_push   = w_accept && (in_addr != '0);
  assign w_pop    = drain_en && !w_empty;

  assign WE    = w_pop;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

  assign wAddr = w_empty ? '0 : r_addr[r_head];
  assign WD    = w_empty ? '0 : r_data[r_head];
  assign PC    = w_empty ? '0 : r_pc[r_head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; every reader is qualified by r_vld
  // or by empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
      r_pc[r_tail]   <= in_pc;
    end
  end

  // Entries listed oldest-first, relative to head, so wrap cannot reorder ages.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign w_idx[g] = r_head + PW'(g);
  end

  always_comb begin
    // NOTE: combinational logic uses blocking assignments with a default first,
    // so later (younger) matches override earlier ones and no latch is inferred.
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[w_idx[k]] && (q_addr_a != '0) && (r_addr[w_idx[k]] == q_addr_a)) begin
        hit_a = 1'b1;
        fwd_a = r_data[w_idx[k]];
      end
      if (r_vld[w_idx[k]] && (q_addr_b != '0) && (r_addr[w_idx[k]] == q_addr_b)) begin
        hit_b = 1'b1;
        fwd_b = r_data[w_idx[k]];
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed plus random bench for grf_wb_queue; a queue of expected GRF writes
// is filled as requests are accepted and drained as WE cycles appear.
module tb_grf_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] p;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_pc;
  logic          drain_en;
  logic          WE;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] WD;
  logic [DW-1:0] PC;
  logic [AW-1:0] q_addr_a;
  logic [AW-1:0] q_addr_b;
  logic          hit_a;
  logic          hit_b;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  logic [DW-1:0] pc_ctr = 32'h0000_1000;

  grf_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_pc(in_pc),
    .drain_en(drain_en),
    .WE(WE), .wAddr(wAddr), .WD(WD), .PC(PC),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
    .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_lookup(input logic [AW-1:0] qa,
                                       output logic h, output logic [DW-1:0] f);
    h = 1'b0;
    f = '0;
    if (qa != '0)
      foreach (sb[i])
        if (sb[i].a == qa) begin
          h = 1'b1;
          f = sb[i].d;
        end
  endfunction

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    pc_ctr   = pc_ctr + 32'd4;
    in_pc    = pc_ctr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
  endtask

  // Settle, compare all outputs against the model, advance the model, then clock.
  task automatic tick();
    logic          exp_ready;
    logic          exp_we;
    logic          h;
    logic [DW-1:0] f;
    ent_t          hd;
    #1;
    exp_ready = (sb.size() < DEPTH);
    exp_we    = rst && drain_en && (sb.size() != 0);
    hd        = (sb.size() != 0) ? sb[0] : '0;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("WE",       64'(WE),       64'(exp_we));
    check("count",    64'(count),    64'(sb.size()));
    check("empty",    64'(empty),    64'(sb.size() == 0));
    check("full",     64'(full),     64'(sb.size() == DEPTH));
    check("wAddr",    64'(wAddr),    64'(hd.a));
    check("WD",       64'(WD),       64'(hd.d));
    check("PC",       64'(PC),       64'(hd.p));
    model_lookup(q_addr_a, h, f);
    check("hit_a", 64'(hit_a), 64'(h));
    check("fwd_a", 64'(fwd_a), 64'(f));
    model_lookup(q_addr_b, h, f);
    check("hit_b", 64'(hit_b), 64'(h));
    check("fwd_b", 64'(fwd_b), 64'(f));
    if (!rst) begin
      sb.delete();
    end else begin
      if (exp_we) void'(sb.pop_front());
      if (in_valid && exp_ready && (in_addr != '0))
        sb.push_back('{a: in_addr, d: in_data, p: in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    drain_en = 1'b1;
    q_addr_a = '0;
    q_addr_b = '0;
    in_pc    = '0;
    send(5'd3, 32'h0000_00C3);

    // Held in reset with a live request: nothing may be accepted or written.
    repeat (3) tick();
    idle();
    rst = 1'b1;
    repeat (2) tick();
    send(5'd3, 32'h0000_005A);
    tick();
    idle();
    tick();

    // Fill to full with no drain, attempt one more, then drain in order.
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(AW'(i), 32'hA0 + 32'(i));
      tick();
    end
    send(5'd9, 32'h0000_00EE);
    tick();
    idle();
    drain_en = 1'b1;
    repeat (5) tick();

    // Youngest-match forwarding, including while the head is draining.
    drain_en = 1'b0;
    q_addr_a = 5'd5;
    q_addr_b = 5'd6;
    send(5'd5, 32'h11);
    tick();
    send(5'd6, 32'h66);
    tick();
    send(5'd5, 32'h22);
    tick();
    idle();
    tick();
    drain_en = 1'b1;
    repeat (4) tick();

    // $0 request completes the handshake but is dropped; lookup of $0 never hits.
    drain_en = 1'b0;
    q_addr_b = 5'd0;
    send(5'd0, 32'hFF);
    tick();
    idle();
    tick();

    // Concurrent accept and drain at count=2, long enough to wrap both pointers.
    send(5'd1, 32'h01);
    tick();
    send(5'd2, 32'h02);
    tick();
    drain_en = 1'b1;
    q_addr_a = 5'd7;
    q_addr_b = 5'd2;
    for (int i = 0; i < 6; i++) begin
      send(5'd7, 32'h33 + 32'(i));
      tick();
    end
    idle();
    repeat (3) tick();

    // Asynchronous reset between edges while draining.
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(AW'(10 + i), 32'hC0 + 32'(i));
      tick();
    end
    idle();
    drain_en = 1'b1;
    #1;
    check("pre_rst_WE",    64'(WE),    64'd1);
    check("pre_rst_count", 64'(count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_WE",    64'(WE),    64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_empty", 64'(empty), 64'd1);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();

    // Random traffic with a narrow address range to stress matches and wrap.
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = AW'($urandom_range(0, 7));
      in_data  = $urandom;
      pc_ctr   = pc_ctr + 32'd4;
      in_pc    = pc_ctr;
      drain_en = ($urandom_range(0, 2) != 0);
      q_addr_a = AW'($urandom_range(0, 7));
      q_addr_b = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    drain_en = 1'b1;
    repeat (DEPTH + 1) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
